// File: rtl/uart_word_rx.sv
// uart_word_rx: UART receive engine that deserialises frames (5..8 data
// bits, optional parity, 1 or 2 stop bits), packs WORD_BYTES consecutive
// bytes into one word and offers it on a valid/ready handshake. A partial
// word is flushed after TIMEOUT_BITS idle bit-times.
module uart_word_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int WORD_BYTES   = 4,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    uart_rx,
    output logic [8*WORD_BYTES-1:0] word_data,
    output logic [3:0]              word_bytes,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    err_parity,
    output logic                    err_frame,
    output logic                    err_overrun
);

    localparam int DIV       = CLK_FREQ / BAUD;
    localparam int CNT_W     = $clog2(DIV);
    // Loading this value makes the START sample land DIV/2 cycles after the edge.
    localparam int HALF_LOAD = DIV - DIV / 2;
    localparam int TO_CYC    = TIMEOUT_BITS * DIV;
    localparam int TO_W      = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                    rx_s1;
    logic                    rx_s2;
    logic                    rx_prev;
    logic                    fall;
    logic [2:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic                    tick;
    logic [2:0]              bitn;
    logic [DATA_BITS-1:0]    shreg;
    logic                    vld_p1;
    logic                    perr_p1;
    logic                    ferr_p1;
    logic [3:0]              idx;
    logic [8*WORD_BYTES-1:0] asm_buf;
    logic [8*WORD_BYTES-1:0] new_buf;
    logic [TO_W-1:0]         tcnt;
    logic                    running;
    logic                    flush;
    logic                    good;
    logic                    complete;
    logic                    load;
    logic [3:0]              load_bytes;

    // Expected parity bit for the received data bits.
    function automatic logic parity_exp(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            return ~(^d);
        end
        return ^d;
    endfunction

    // Zero-extend a DATA_BITS character to a byte lane.
    function automatic logic [7:0] to_byte(input logic [DATA_BITS-1:0] d);
        logic [7:0] b;
        b = '0;
        b[DATA_BITS-1:0] = d;
        return b;
    endfunction

    assign fall = rx_prev & ~rx_s2;
    assign tick = (cnt == CNT_W'(DIV - 1));

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Data shift register: LSB arrives first, so shift in from the top.
    always_ff @(posedge sys_clk) begin
        if (state == S_DATA && tick) begin
            shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
        end
    end

    // Frame FSM; vld_p1 marks the cycle after the last stop sample.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bitn    <= '0;
            vld_p1  <= 1'b0;
            perr_p1 <= 1'b0;
            ferr_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (state != S_IDLE) begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state   <= S_START;
                        cnt     <= CNT_W'(HALF_LOAD);
                        perr_p1 <= 1'b0;
                        ferr_p1 <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_s2) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                            bitn  <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bitn == 3'(DATA_BITS - 1)) begin
                            bitn  <= '0;
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bitn <= bitn + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        perr_p1 <= (rx_s2 != parity_exp(shreg));
                        bitn    <= '0;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (!rx_s2) begin
                            ferr_p1 <= 1'b1;
                            state   <= S_IDLE;
                            vld_p1  <= 1'b1;
                        end else if (bitn == 3'(STOP_BITS - 1)) begin
                            state  <= S_IDLE;
                            vld_p1 <= 1'b1;
                        end else begin
                            bitn <= bitn + 3'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Completion and flush decisions, and the buffer with the new byte merged in.
    always_comb begin
        good       = vld_p1 && !perr_p1 && !ferr_p1;
        running    = (state == S_IDLE) && (idx != 4'd0);
        flush      = (TIMEOUT_BITS != 0) && running && !vld_p1 && !fall
                     && (tcnt == TO_W'(TO_CYC - 1));
        complete   = good && (idx == 4'(WORD_BYTES - 1));
        load       = complete || flush;
        load_bytes = complete ? 4'(WORD_BYTES) : idx;
        new_buf    = asm_buf;
        if (good) begin
            new_buf[8*int'(idx) +: 8] = to_byte(shreg);
        end
    end

    // Inter-byte idle timer; only counts while a partial word waits in IDLE.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (!running || fall || vld_p1 || flush) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TO_W'(1);
        end
    end

    // Word assembly, output handshake and error pulses.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            word_data   <= '0;
            word_bytes  <= '0;
            word_valid  <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
            idx         <= '0;
            asm_buf     <= '0;
        end else begin
            err_parity  <= vld_p1 & perr_p1;
            err_frame   <= vld_p1 & ferr_p1;
            err_overrun <= 1'b0;
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (load) begin
                idx     <= '0;
                asm_buf <= '0;
                // An acceptance on this same edge frees the output register.
                if (!word_valid || word_ready) begin
                    word_data  <= new_buf;
                    word_bytes <= load_bytes;
                    word_valid <= 1'b1;
                end else begin
                    err_overrun <= 1'b1;
                end
            end else if (good) begin
                asm_buf <= new_buf;
                idx     <= idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// Testbench for uart_word_rx: three instances (no parity / even parity /
// timeout disabled), each with its own serial line, checked through a
// scoreboard of expected words and counters of error pulses.
`timescale 1ns/1ps
module tb_uart_word_rx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = CLK_FREQ / BAUD;

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic [3:0]  nbytes;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line   [3];
    logic        rdy    [3];
    logic [31:0] wdata  [3];
    logic [3:0]  wbytes [3];
    logic        wvalid [3];
    logic        perr   [3];
    logic        ferr   [3];
    logic        ovr    [3];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   nacc   [3] = '{0, 0, 0};
    int   n_perr [3] = '{0, 0, 0};
    int   n_ferr [3] = '{0, 0, 0};
    int   n_ovr  [3] = '{0, 0, 0};
    exp_t expq[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    uart_word_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .WORD_BYTES(4), .TIMEOUT_BITS(20)) dut0 (
        .sys_clk(clk), .rst(rst), .uart_rx(line[0]), .word_data(wdata[0]),
        .word_bytes(wbytes[0]), .word_valid(wvalid[0]), .word_ready(rdy[0]),
        .err_parity(perr[0]), .err_frame(ferr[0]), .err_overrun(ovr[0]));

    uart_word_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .WORD_BYTES(4), .TIMEOUT_BITS(20)) dut1 (
        .sys_clk(clk), .rst(rst), .uart_rx(line[1]), .word_data(wdata[1]),
        .word_bytes(wbytes[1]), .word_valid(wvalid[1]), .word_ready(rdy[1]),
        .err_parity(perr[1]), .err_frame(ferr[1]), .err_overrun(ovr[1]));

    uart_word_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .WORD_BYTES(4), .TIMEOUT_BITS(0)) dut2 (
        .sys_clk(clk), .rst(rst), .uart_rx(line[2]), .word_data(wdata[2]),
        .word_bytes(wbytes[2]), .word_valid(wvalid[2]), .word_ready(rdy[2]),
        .err_parity(perr[2]), .err_frame(ferr[2]), .err_overrun(ovr[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int d, input logic [7:0] b, input bit use_par,
                              input bit par_bit, input bit stop_low);
        line[d] = 1'b0;
        cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            line[d] = b[i];
            cyc(DIV);
        end
        if (use_par) begin
            line[d] = par_bit;
            cyc(DIV);
        end
        line[d] = ~stop_low;
        cyc(DIV);
        line[d] = 1'b1;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b);
        send_frame(d, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input int d, input logic [31:0] data, input logic [3:0] n);
        exp_t e;
        e.dut    = d;
        e.data   = data;
        e.nbytes = n;
        expq.push_back(e);
    endtask

    task automatic wait_acc(input int d, input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (nacc[d] < target && k < budget) begin
            cyc(1);
            k++;
        end
        chk(tag, 64'(nacc[d]), 64'(target));
    endtask

    // Monitor: count error pulses and check every accepted word against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (perr[d]) n_perr[d]++;
                if (ferr[d]) n_ferr[d]++;
                if (ovr[d])  n_ovr[d]++;
                if (wvalid[d] && rdy[d]) begin
                    nacc[d]++;
                    if (expq.size() == 0) begin
                        chk($sformatf("d%0d_unexpected_word", d), 64'(expq.size()), 64'd1);
                    end else begin
                        mon_e = expq.pop_front();
                        chk($sformatf("d%0d_word_source", d), 64'(d), 64'(mon_e.dut));
                        chk($sformatf("d%0d_word_data", d), 64'(wdata[d]), 64'(mon_e.data));
                        chk($sformatf("d%0d_word_bytes", d), 64'(wbytes[d]), 64'(mon_e.nbytes));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         p0;
        for (int d = 0; d < 3; d++) begin
            line[d] = 1'b1;
            rdy[d]  = 1'b1;
        end
        rst = 1'b1;
        cyc(5);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid%0d", d),  64'(wvalid[d]), 64'd0);
            chk($sformatf("rst_data%0d", d),   64'(wdata[d]),  64'd0);
            chk($sformatf("rst_bytes%0d", d),  64'(wbytes[d]), 64'd0);
            chk($sformatf("rst_perr%0d", d),   64'(perr[d]),   64'd0);
            chk($sformatf("rst_ferr%0d", d),   64'(ferr[d]),   64'd0);
            chk($sformatf("rst_ovr%0d", d),    64'(ovr[d]),    64'd0);
        end
        rst = 1'b0;
        cyc(20);

        // Four back-to-back bytes form one word.
        push(0, 32'h04030201, 4'd4);
        for (int i = 1; i <= 4; i++) send_byte(0, 8'(i));
        wait_acc(0, 1, 50, "t1_accept");
        chk("t1_perr", 64'(n_perr[0]), 64'd0);
        chk("t1_ferr", 64'(n_ferr[0]), 64'd0);
        chk("t1_ovr",  64'(n_ovr[0]),  64'd0);

        // Even parity: a bad-parity byte is dropped, then four good bytes.
        send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b0);
        push(1, 32'h14131211, 4'd4);
        for (int i = 0; i < 4; i++) begin
            b = 8'h11 + 8'(i);
            send_frame(1, b, 1'b1, ^b, 1'b0);
        end
        wait_acc(1, 1, 50, "t2_accept");
        chk("t2_perr", 64'(n_perr[1]), 64'd1);
        chk("t2_ferr", 64'(n_ferr[1]), 64'd0);

        // Short glitch is a false start; then a frame with a low stop bit.
        line[0] = 1'b0;
        cyc(3);
        line[0] = 1'b1;
        cyc(30);
        chk("t3_glitch_words", 64'(nacc[0]),   64'd1);
        chk("t3_glitch_ferr",  64'(n_ferr[0]), 64'd0);
        chk("t3_glitch_perr",  64'(n_perr[0]), 64'd0);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        cyc(20);
        chk("t3_ferr", 64'(n_ferr[0]), 64'd1);
        cyc(250);
        chk("t3_no_flush", 64'(nacc[0]), 64'd1);
        push(0, 32'h24232221, 4'd4);
        for (int i = 0; i < 4; i++) send_byte(0, 8'h21 + 8'(i));
        wait_acc(0, 2, 50, "t3_after_ferr");

        // Overrun: consumer stalled across two words.
        rdy[0] = 1'b0;
        push(0, 32'h04030201, 4'd4);
        for (int i = 1; i <= 8; i++) send_byte(0, 8'(i));
        cyc(20);
        chk("t4_ovr",       64'(n_ovr[0]),  64'd1);
        chk("t4_valid",     64'(wvalid[0]), 64'd1);
        chk("t4_held_data", 64'(wdata[0]),  64'h04030201);
        chk("t4_held_bytes",64'(wbytes[0]), 64'd4);
        chk("t4_stalled",   64'(nacc[0]),   64'd2);
        rdy[0] = 1'b1;
        wait_acc(0, 3, 10, "t4_accept");
        cyc(3);
        chk("t4_valid_low", 64'(wvalid[0]), 64'd0);
        chk("t4_acc_once",  64'(nacc[0]),   64'd3);

        // Timeout flush of a two-byte partial word.
        push(0, 32'h0000BBAA, 4'd2);
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        cyc(170);
        chk("t5_not_early", 64'(nacc[0]), 64'd3);
        wait_acc(0, 4, 100, "t5_flush");

        // Timeout disabled: partial bytes are held until the word fills.
        send_byte(2, 8'hAA);
        send_byte(2, 8'hBB);
        cyc(400);
        chk("t5_no_flush", 64'(nacc[2]), 64'd0);
        push(2, 32'hDDCCBBAA, 4'd4);
        send_byte(2, 8'hCC);
        send_byte(2, 8'hDD);
        wait_acc(2, 1, 50, "t5_dut2_word");

        // Reset in the middle of the second byte discards everything.
        p0 = n_perr[0] + n_ferr[0] + n_ovr[0];
        send_byte(0, 8'h31);
        line[0] = 1'b0;
        cyc(25);
        rst = 1'b1;
        cyc(3);
        line[0] = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(30);
        chk("t6_no_pulses", 64'(n_perr[0] + n_ferr[0] + n_ovr[0]), 64'(p0));
        chk("t6_valid",     64'(wvalid[0]), 64'd0);
        chk("t6_no_word",   64'(nacc[0]),   64'd4);
        push(0, 32'h44434241, 4'd4);
        for (int i = 0; i < 4; i++) send_byte(0, 8'h41 + 8'(i));
        wait_acc(0, 5, 50, "t6_fresh");
        cyc(300);
        chk("t6_no_extra", 64'(nacc[0]), 64'd5);

        chk("queue_empty", 64'(expq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
